// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// Byte address layout: [tag | index | word offset | 2-bit byte offset].
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    REFILL = 2'd2
  } icache_state_e;

  // Bits selecting a word inside a line
  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Bits selecting a line
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction

  // Whatever is left above index and word offset
  function automatic int tag_w(input int addr_w, input int lines, input int words_per_line);
    return addr_w - 2 - $clog2(lines) - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data storage: LINES x WORDS_PER_LINE words, one synchronous
// write port fed by refill beats, one asynchronous read port for hits.
// Contents are not reset; the valid bits in icache_dm guard stale data.
module icache_data_ram
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int DATA_W         = 32
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic [index_w(LINES)-1:0]           wr_index,
  input  logic [offset_w(WORDS_PER_LINE)-1:0] wr_word,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic [index_w(LINES)-1:0]           rd_index,
  input  logic [offset_w(WORDS_PER_LINE)-1:0] rd_word,
  output logic [DATA_W-1:0]                   rd_data
);

  logic [DATA_W-1:0] mem [LINES][WORDS_PER_LINE];

  // Each accepted refill beat lands in its slot of the line being filled
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_index][wr_word] <= wr_data;
    end
  end

  assign rd_data = mem[rd_index][rd_word];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache for the fetch stage. Hits are served
// combinationally; a miss stalls fetch, requests the line and refills it
// word by word. flush (fence.i) invalidates every line.
// Optional feature: define ICACHE_PERF_EN to add hit_cnt / miss_cnt.
// reset is asynchronous and active-low; while it is low every output reads 0.
module icache_dm
  import icache_pkg::*;
#(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int OFF_W  = offset_w(WORDS_PER_LINE);
  localparam int IDX_W  = index_w(LINES);
  localparam int TAG_W  = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int LINE_W = ADDR_W - 2 - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  icache_state_e     state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [LINE_W-1:0] req_line;
  logic [OFF_W-1:0]  beat;
  logic              flush_pending;

  logic [OFF_W-1:0]  fetch_word;
  logic [IDX_W-1:0]  fetch_index;
  logic [TAG_W-1:0]  fetch_tag;
  logic [IDX_W-1:0]  req_index;
  logic [TAG_W-1:0]  req_tag;
  logic [DATA_W-1:0] rd_data;
  logic              hit;
  logic              idle_fetch;
  logic              hit_now;
  logic              miss_now;
  logic              last_beat;
  logic              unused_addr_bits;

  assign fetch_word       = fetch_addr[OFF_W+1:2];
  assign fetch_index      = fetch_addr[OFF_W+IDX_W+1:OFF_W+2];
  assign fetch_tag        = fetch_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign unused_addr_bits = ^fetch_addr[1:0];

  assign req_index = req_line[IDX_W-1:0];
  assign req_tag   = req_line[LINE_W-1:IDX_W];

  assign hit        = valid[fetch_index] && (tags[fetch_index] == fetch_tag);
  assign idle_fetch = reset && (state == IDLE) && fetch_valid;
  assign hit_now    = idle_fetch && hit;
  assign miss_now   = idle_fetch && !hit;
  assign last_beat  = (state == REFILL) && mem_rsp_valid && (beat == LAST_BEAT);

  assign instr         = hit_now ? rd_data : '0;
  assign instr_valid   = hit_now;
  assign stall         = miss_now || (reset && (state != IDLE));
  assign mem_req_valid = reset && (state == REQ);
  assign mem_req_addr  = mem_req_valid ? {req_line, {(OFF_W + 2){1'b0}}} : '0;

  icache_data_ram #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .DATA_W         (DATA_W)
  ) u_data_ram (
    .clk      (clk),
    .wr_en    ((state == REFILL) && mem_rsp_valid),
    .wr_index (req_index),
    .wr_word  (beat),
    .wr_data  (mem_rsp_data),
    .rd_index (fetch_index),
    .rd_word  (fetch_word),
    .rd_data  (rd_data)
  );

  // Miss handling: latch the line, request it, count beats until it is full
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      beat          <= '0;
      flush_pending <= 1'b0;
      req_line      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_now) begin
            req_line <= fetch_addr[ADDR_W-1:OFF_W+2];
            state    <= REQ;
          end
        end
        REQ: begin
          if (flush) begin
            flush_pending <= 1'b1;
          end
          if (mem_req_ready) begin
            beat  <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (flush) begin
            flush_pending <= 1'b1;
          end
          if (mem_rsp_valid) begin
            beat <= beat + OFF_W'(1);
            if (beat == LAST_BEAT) begin
              flush_pending <= 1'b0;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Valid bits: set when a refill finishes, wiped by any flush seen so far
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if ((state == IDLE) && flush) begin
      valid <= '0;
    end else if (last_beat) begin
      if (flush_pending || flush) begin
        valid <= '0;
      end else begin
        valid[req_index] <= 1'b1;
      end
    end
  end

  // Tag is written together with the final beat of the line
  always_ff @(posedge clk) begin
    if (last_beat) begin
      tags[req_index] <= req_tag;
    end
  end

`ifdef ICACHE_PERF_EN
  // Hit and miss event counters; they wrap and survive fence.i
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_now) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss_now) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
